// File: rtl/best_arr_sender_pkg.sv
// rtl/best_arr_sender_pkg.sv - shared defaults, state enum and helpers for the best-index sender
package best_arr_sender_pkg;

  localparam int DEF_DATA_WIDTH = 11;
  localparam int DEF_ROW_SIZE   = 26;
  localparam int DEF_COL_SIZE   = 19;
  localparam int DEF_BLOCKING   = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/best_arr_sender_blocked_addr_gen.sv
// rtl/best_arr_sender_blocked_addr_gen.sv - blocked-order address generator (half-row, block, row, column)
module blocked_addr_gen
  import best_arr_sender_pkg::*;
#(
  parameter int ROW_SIZE   = DEF_ROW_SIZE,
  parameter int COL_SIZE   = DEF_COL_SIZE,
  parameter int BLOCKING   = DEF_BLOCKING,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int HALF   = ROW_SIZE / 2;
  localparam int NBLK   = ceil_div(HALF, BLOCKING);
  localparam int LAST_W = HALF - (NBLK - 1) * BLOCKING;
  localparam int XW     = $clog2(NBLK + 1);
  localparam int YW     = $clog2(COL_SIZE + 1);
  localparam int IW     = $clog2(BLOCKING + 1);

  logic                  r_px;
  logic [XW-1:0]         r_x;
  logic [YW-1:0]         r_y;
  logic [IW-1:0]         r_xi;
  // r_col: start of the current block column at y=0; r_line: start of the current row within it
  logic [ADDR_WIDTH-1:0] r_col;
  logic [ADDR_WIDTH-1:0] r_line;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_last_blk;
  logic                  w_xi_end;
  logic                  w_y_end;
  logic [ADDR_WIDTH-1:0] w_next_row;
  logic [ADDR_WIDTH-1:0] w_next_blk;
  logic [ADDR_WIDTH-1:0] w_next_half;

  assign w_last_blk  = (r_x == XW'(NBLK - 1));
  assign w_xi_end    = (r_xi == (w_last_blk ? IW'(LAST_W - 1) : IW'(BLOCKING - 1)));
  assign w_y_end     = (r_y == YW'(COL_SIZE - 1));
  assign w_next_row  = r_line + ADDR_WIDTH'(ROW_SIZE);
  assign w_next_blk  = r_col + ADDR_WIDTH'(BLOCKING);
  assign w_next_half = r_px ? '0 : ADDR_WIDTH'(HALF);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_px   <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_xi   <= '0;
      r_col  <= '0;
      r_line <= '0;
      r_addr <= '0;
    end else if (advance) begin
      if (!w_xi_end) begin
        r_xi   <= r_xi + 1'b1;
        r_addr <= r_addr + 1'b1;
      end else begin
        r_xi <= '0;
        if (!w_y_end) begin
          r_y    <= r_y + 1'b1;
          r_line <= w_next_row;
          r_addr <= w_next_row;
        end else begin
          r_y <= '0;
          if (!w_last_blk) begin
            r_x    <= r_x + 1'b1;
            r_col  <= w_next_blk;
            r_line <= w_next_blk;
            r_addr <= w_next_blk;
          end else begin
            // wraps back to address 0 after the final tuple of the second half
            r_x    <= '0;
            r_px   <= ~r_px;
            r_col  <= w_next_half;
            r_line <= w_next_half;
            r_addr <= w_next_half;
          end
        end
      end
    end
  end

  assign addr = r_addr;
  assign last = r_px && w_last_blk && w_y_end && w_xi_end;

endmodule

// File: rtl/best_arr_sender.sv
// rtl/best_arr_sender.sv - streams best-match indices from RAM to the output FIFO in blocked order
module best_arr_sender
  import best_arr_sender_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int ROW_SIZE   = DEF_ROW_SIZE,
  parameter  int COL_SIZE   = DEF_COL_SIZE,
  parameter  int BLOCKING   = DEF_BLOCKING,
  localparam int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  localparam int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fifo_wenq,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  input  logic                  fifo_wfull_n
);

  state_e                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_inflight;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic                  w_last;
  logic                  w_clear;
  logic [2:0]            w_pending;

  // Occupancy net of the word leaving this cycle, so a full-rate stream keeps one read per cycle.
  assign w_pending = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_wenq = rst_n && (r_count != 2'd0);
  assign w_pop     = fifo_wenq && fifo_wfull_n;
  assign w_push    = r_inflight;
  assign w_issue   = rst_n && (r_state == RUN) && (w_pending < 3'd2);
  assign w_clear   = (r_state == IDLE) && start;

  blocked_addr_gen #(
    .ROW_SIZE  (ROW_SIZE),
    .COL_SIZE  (COL_SIZE),
    .BLOCKING  (BLOCKING),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .advance(w_issue),
    .addr   (mem_raddr),
    .last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (w_issue && w_last) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_pending == 3'd0) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Two-entry holding buffer; r_buf0 is always the head presented to the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= w_issue;
      unique case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_buf0 <= mem_rdata;
          else                 r_buf1 <= mem_rdata;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf0  <= r_buf1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf0 <= mem_rdata;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign mem_ren    = w_issue;
  assign fifo_wdata = r_buf0;

endmodule

// File: tb/tb_best_arr_sender.sv
// tb/tb_best_arr_sender.sv - self-checking bench for best_arr_sender with a blocked-order reference model
module tb_best_arr_sender;

  localparam int DW  = 11;
  localparam int NQ  = 26 * 19;
  localparam int AW  = 9;
  localparam int NQ2 = 16 * 3;
  localparam int AW2 = 6;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, mem_ren, fifo_wenq, fifo_wfull_n;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata, fifo_wdata;

  logic           start2, busy2, done2, ren2, wenq2, wfull2;
  logic [AW2-1:0] raddr2;
  logic [DW-1:0]  rdata2, wdata2;

  always #5 clk = ~clk;

  best_arr_sender dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .fifo_wenq(fifo_wenq), .fifo_wdata(fifo_wdata), .fifo_wfull_n(fifo_wfull_n)
  );

  best_arr_sender #(.DATA_WIDTH(DW), .ROW_SIZE(16), .COL_SIZE(3), .BLOCKING(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .mem_ren(ren2), .mem_raddr(raddr2), .mem_rdata(rdata2),
    .fifo_wenq(wenq2), .fifo_wdata(wdata2), .fifo_wfull_n(wfull2)
  );

  logic [DW-1:0] ram [0:NQ-1];
  always @(posedge clk) if (mem_ren) mem_rdata <= ram[mem_raddr];
  always @(posedge clk) if (ren2) rdata2 <= DW'(raddr2);

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  logic [DW-1:0] got[$];
  logic [DW-1:0] got2[$];
  int  rd_cnt [0:511];
  int  n_acc, n_rd, max_out, stab_err, done_cnt, done2_cnt;
  int  start_cyc, first_wen, first_acc, last_acc, done_cyc;
  bit  prev_stall;
  logic [DW-1:0] prev_data;

  int exp_addr[$];
  int exp_addr2[$];

  always @(negedge clk) begin
    if (start && start_cyc < 0) start_cyc = cyc;
    if (fifo_wenq && first_wen < 0) first_wen = cyc;
    if (fifo_wenq && fifo_wfull_n) begin
      got.push_back(fifo_wdata);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      n_acc++;
    end
    if (mem_ren) begin
      n_rd++;
      rd_cnt[mem_raddr]++;
    end
    if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
    if (prev_stall && (!fifo_wenq || fifo_wdata !== prev_data)) stab_err++;
    prev_stall = fifo_wenq && !fifo_wfull_n;
    prev_data  = fifo_wdata;
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (wenq2 && wfull2) got2.push_back(wdata2);
    if (done2) done2_cnt++;
  end

  // Reference order straight from the nested-loop definition of the blocked layout.
  function automatic void build_order(input int row, input int col, input int blk);
    int half, nblk, lastw, w;
    half  = row / 2;
    nblk  = (half + blk - 1) / blk;
    lastw = half - (nblk - 1) * blk;
    exp_addr.delete();
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < nblk; x++)
        for (int y = 0; y < col; y++) begin
          w = (x == nblk - 1) ? lastw : blk;
          for (int xi = 0; xi < w; xi++)
            exp_addr.push_back(px * half + y * row + x * blk + xi);
        end
  endfunction

  function automatic int seq_errors();
    int e = 0;
    for (int i = 0; i < exp_addr.size(); i++)
      if (i >= got.size() || got[i] !== ram[exp_addr[i]]) e++;
    return e;
  endfunction

  function automatic int reads_bad();
    int b = 0;
    for (int a = 0; a < 512; a++)
      if ((a < NQ && rd_cnt[a] != 1) || (a >= NQ && rd_cnt[a] != 0)) b++;
    return b;
  endfunction

  task automatic clear_mon();
    got.delete();
    n_acc = 0; n_rd = 0; max_out = 0; stab_err = 0; done_cnt = 0;
    start_cyc = -1; first_wen = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
    prev_stall = 1'b0;
    for (int a = 0; a < 512; a++) rd_cnt[a] = 0;
  endtask

  task automatic fill_ram(input bit identity);
    for (int i = 0; i < NQ; i++) ram[i] = identity ? DW'(i) : DW'($urandom);
  endtask

  task automatic run_stream(input int lowpct, input int stall_at, input int stall_len,
                            input int restart_at, output bit timed_out);
    int  stalled = 0;
    bit  restarted = 1'b0;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1; fifo_wfull_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    timed_out = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      if (restart_at >= 0 && !restarted && got.size() >= restart_at) begin
        start = 1'b1; restarted = 1'b1;
      end else start = 1'b0;
      if (stall_at >= 0 && got.size() >= stall_at && stalled < stall_len) begin
        fifo_wfull_n = 1'b0; stalled++;
      end else fifo_wfull_n = ($urandom_range(99) >= lowpct);
      @(posedge clk); #1;
      if (done_cnt != 0) begin timed_out = 1'b0; break; end
    end
    start = 1'b0; fifo_wfull_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; fifo_wfull_n = 1'b1; wfull2 = 1'b1;
    clear_mon(); got2.delete(); done2_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, mem_ren, fifo_wenq, busy2, ren2, wenq2} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b exp=0", {busy, done, mem_ren, fifo_wenq, busy2, ren2, wenq2});
    end
  endtask

  task automatic test_stream_no_bp();
    bit to;
    fill_ram(1'b1);
    build_order(26, 19, 4);
    run_stream(0, -1, 0, -1, to);
    checks++; if (to) begin failures++; $display("FAIL nobp_timeout got=no_done exp=done"); end
    checks++; if (got.size() !== NQ) begin failures++; $display("FAIL nobp_count got=%0d exp=%0d", got.size(), NQ); end
    checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL nobp_sequence got=%0d_bad exp=0", seq_errors()); end
    checks++; if (got[4] !== DW'(26)) begin failures++; $display("FAIL nobp_word4 got=%0d exp=26", got[4]); end
    checks++; if (got[247] !== DW'(13) || got[250] !== DW'(16)) begin
      failures++; $display("FAIL nobp_half1_start got=%0d,%0d exp=13,16", got[247], got[250]); end
    checks++; if (got[NQ-1] !== DW'(493)) begin failures++; $display("FAIL nobp_last got=%0d exp=493", got[NQ-1]); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL nobp_done_count got=%0d exp=1", done_cnt); end
    checks++; if (first_wen - start_cyc !== 3) begin
      failures++; $display("FAIL nobp_first_latency got=%0d exp=3", first_wen - start_cyc); end
    checks++; if (done_cyc - start_cyc > NQ + 4 || done_cyc < 0) begin
      failures++; $display("FAIL nobp_done_latency got=%0d exp<=%0d", done_cyc - start_cyc, NQ + 4); end
    checks++; if (last_acc - first_acc + 1 !== NQ) begin
      failures++; $display("FAIL nobp_gapless got=%0d exp=%0d", last_acc - first_acc + 1, NQ); end
    checks++; if (reads_bad() !== 0) begin failures++; $display("FAIL nobp_reads_once got=%0d_bad exp=0", reads_bad()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nobp_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_random_bp();
    bit to;
    fill_ram(1'b0);
    build_order(26, 19, 4);
    run_stream(50, -1, 0, -1, to);
    checks++; if (to) begin failures++; $display("FAIL rbp_timeout got=no_done exp=done"); end
    checks++; if (got.size() !== NQ) begin failures++; $display("FAIL rbp_count got=%0d exp=%0d", got.size(), NQ); end
    checks++; if (seq_errors() !== 0) begin failures++; $display("FAIL rbp_sequence got=%0d_bad exp=0", seq_errors()); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL rbp_stable got=%0d exp=0", stab_err); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL rbp_outstanding got=%0d exp<=2", max_out); end
    checks++; if (reads_bad() !== 0) begin failures++; $display("FAIL rbp_reads_once got=%0d_bad exp=0", reads_bad()); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rbp_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_long_stall();
    bit to;
    fill_ram(1'b0);
    build_order(26, 19, 4);
    run_stream(0, 200, 100, -1, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=no_done exp=done"); end
    checks++; if (max_out > 2) begin failures++; $display("FAIL stall_outstanding got=%0d exp<=2", max_out); end
    checks++; if (got.size() !== NQ || seq_errors() !== 0) begin
      failures++; $display("FAIL stall_sequence got=%0d_words_%0d_bad exp=%0d_words_0_bad", got.size(), seq_errors(), NQ); end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stab_err); end
  endtask

  task automatic test_restart_ignored();
    bit to;
    fill_ram(1'b0);
    build_order(26, 19, 4);
    run_stream(20, -1, 0, 100, to);
    checks++; if (got.size() !== NQ || seq_errors() !== 0) begin
      failures++; $display("FAIL restart_sequence got=%0d_words_%0d_bad exp=%0d_words_0_bad", got.size(), seq_errors(), NQ); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", done_cnt); end
    checks++; if (reads_bad() !== 0) begin failures++; $display("FAIL restart_reads_once got=%0d_bad exp=0", reads_bad()); end
  endtask

  task automatic test_mid_reset();
    bit to;
    int acc0, rd0;
    fill_ram(1'b0);
    build_order(26, 19, 4);
    clear_mon();
    @(posedge clk); #1; start = 1'b1; fifo_wfull_n = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 2000 && got.size() < 200; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=%b exp=0", {busy, done, mem_ren, fifo_wenq, mem_raddr, fifo_wdata});
    end
    acc0 = n_acc; rd0 = n_rd;
    repeat (320) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0 || n_acc !== acc0 || n_rd !== rd0) begin
      failures++;
      $display("FAIL midreset_quiet got=done%0d_acc%0d_rd%0d exp=done0_acc%0d_rd%0d", done_cnt, n_acc - acc0, n_rd - rd0, 0, 0);
    end
    run_stream(0, -1, 0, -1, to);
    checks++; if (to || got.size() !== NQ || seq_errors() !== 0) begin
      failures++; $display("FAIL midreset_fresh got=%0d_words_%0d_bad exp=%0d_words_0_bad", got.size(), seq_errors(), NQ); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL midreset_done_count got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_variant();
    int bad = 0;
    build_order(16, 3, 4);
    exp_addr2 = exp_addr;
    got2.delete(); done2_cnt = 0;
    @(posedge clk); #1; start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    for (int c = 0; c < 300 && done2_cnt == 0; c++) begin
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < exp_addr2.size(); i++)
      if (i >= got2.size() || got2[i] !== DW'(exp_addr2[i])) bad++;
    checks++; if (got2.size() !== NQ2) begin failures++; $display("FAIL var_count got=%0d exp=%0d", got2.size(), NQ2); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL var_sequence got=%0d_bad exp=0", bad); end
    checks++; if (got2[4] !== DW'(16) || got2[8] !== DW'(32) || got2[12] !== DW'(4)) begin
      failures++; $display("FAIL var_spot got=%0d,%0d,%0d exp=16,32,4", got2[4], got2[8], got2[12]); end
    checks++; if (done2_cnt !== 1) begin failures++; $display("FAIL var_done got=%0d exp=1", done2_cnt); end
  endtask

  initial begin
    test_reset();
    test_stream_no_bp();
    test_random_bp();
    test_long_stall();
    test_restart_ignored();
    test_mid_reset();
    test_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
